serial_frame_receiver: RTL and testbench

- Framed serial deserializer that sits directly downstream of the 8-bit shift-register stage and consumes its serial output (MSB first).
- Detects a start bit, oversamples each bit at mid-period, assembles DATA_W bits, checks the stop bit, and presents the word on a one-entry valid/ready output holding register.
- Flags framing errors and overruns for the channel controller.

---
 rtl/serial_frame_receiver.sv | 206 ++++++++++++++++++++
 tb/tb_serial_frame_receiver.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - framed serial deserializer with valid/ready output holding register
//
// Receives frames of the form: start bit (1), DATA_W data bits MSB first, stop bit (0).
// The line idles at 0. Each bit lasts CLKS_PER_BIT clk cycles. The start bit is
// confirmed at half a bit period, and each later bit is sampled one full period after that.
// A finished word waits in a one-entry holding register until the consumer accepts it.
//
// Optional build macro: SERIAL_FRAME_RECEIVER_PARITY_EN
//   When it is defined, an even-parity bit follows the data bits, and the parity_err port is added.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   sin          serial line input (idle 0, start 1, stop 0)
//   rx_data      received word; holds steady while rx_valid=1
//   rx_valid     a word is waiting in the holding register
//   rx_ready     the consumer accepts the word on an edge where rx_valid & rx_ready
//   frame_err    one-cycle pulse when the stop bit is bad
//   overrun      sticky flag; set when a good frame is dropped because the register is full
//   clr_overrun  synchronous clear of overrun (a set in the same cycle wins)
//   busy         high in every state except IDLE
//   parity_err   (parity build only) one-cycle pulse when parity fails and the stop bit is good

module serial_frame_receiver #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sin,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun,
    input  logic              clr_overrun,
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    localparam int HALF   = CLKS_PER_BIT / 2;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT) + 1;
    localparam int BITS_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BITS_W-1:0] WORD_LAST = BITS_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    state_t              state;
    logic                sin_q;
    logic [CNT_W-1:0]    cnt;
    logic [BITS_W-1:0]   bitcnt;
    logic [DATA_W-1:0]   shreg;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
    logic                par_bit;
`endif
    logic                word_ok;

    // The holding register only accepts a word when the frame checks passed.
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
    assign word_ok = ~(^shreg ^ par_bit);
`else
    assign word_ok = 1'b1;
`endif

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            sin_q     <= 1'b0;
            cnt       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sin_q     <= sin;
            frame_err <= 1'b0;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
            parity_err <= 1'b0;
`endif
            // Default handshake: an accepted word leaves the register. The STOP branch
            // below can override this when a new word loads on the same edge.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            // A clear is written first, so that an overrun set later in this block wins.
            if (clr_overrun) begin
                overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (sin_q) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end

                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (sin_q) begin
                            state  <= ST_DATA;
                            bitcnt <= '0;
                        end else begin
                            // The line dropped before mid-bit: treat it as a glitch and report nothing.
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt    <= '0;
                        shreg  <= {shreg[DATA_W-2:0], sin_q};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == WORD_LAST) begin
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
                ST_PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        par_bit <= sin_q;
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (!sin_q) begin
                            state <= ST_IDLE;
                            if (word_ok) begin
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shreg;
                                    rx_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
                                parity_err <= 1'b1;
`endif
                            end
                        end else begin
                            // A bad stop bit can only be reported as a framing error.
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_BREAK: begin
                    // Hold here until the line falls, so a stuck-high line cannot start a new frame.
                    if (!sin_q) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - randomized self-checking bench for serial_frame_receiver

module tb_serial_frame_receiver;

    localparam int DW   = 8;
    localparam int CPB  = 4;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 1 + HALF + (DW + 1) * CPB;

    logic          clk = 1'b0;
    logic          reset;
    logic          sin;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_err;
    logic          overrun;
    logic          clr_overrun;
    logic          busy;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
    logic          parity_err;
`endif

    serial_frame_receiver #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .sin         (sin),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
        .parity_err  (parity_err),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            edge_idx;
        bit            good;
        logic [DW-1:0] data;
    } ev_t;

    ev_t           events[$];
    bit            sin_fifo[$];
    int            edge_cnt;
    int            n_cmp;
    int            n_err;
    int            ready_mode;
    int            ready_edge;
    bit            clr_rand;
    bit            clr_force;
    bit            m_valid;
    logic [DW-1:0] m_data;
    bit            m_ovr;
    bit            exp_ferr;
    int            ferr_count;
    logic [DW-1:0] last_rx;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    // Frame-level reference: every frame turns into one outcome at a fixed edge, and the
    // holding register and overrun flag follow the handshake rules at that edge.
    task automatic model_edge();
        bit            ev_good;
        bit            ev_bad;
        bit            set_ovr;
        logic [DW-1:0] ev_data;
        ev_good = 1'b0;
        ev_bad  = 1'b0;
        set_ovr = 1'b0;
        ev_data = '0;
        if (events.size() > 0 && events[0].edge_idx == edge_cnt) begin
            ev_good = events[0].good;
            ev_bad  = !events[0].good;
            ev_data = events[0].data;
            void'(events.pop_front());
        end
        exp_ferr = ev_bad;
        if (ev_good && (!m_valid || rx_ready)) begin
            m_data  = ev_data;
            m_valid = 1'b1;
        end else if (ev_good) begin
            set_ovr = 1'b1;
        end else if (m_valid && rx_ready) begin
            m_valid = 1'b0;
        end
        if (clr_overrun) m_ovr = 1'b0;
        if (set_ovr)     m_ovr = 1'b1;
    endtask

    task automatic step();
        sin = (sin_fifo.size() > 0) ? sin_fifo.pop_front() : 1'b0;
        case (ready_mode)
            0:       rx_ready = 1'b0;
            1:       rx_ready = 1'b1;
            2:       rx_ready = 1'($urandom_range(0, 1));
            default: rx_ready = (edge_cnt == ready_edge);
        endcase
        clr_overrun = clr_rand ? ($urandom_range(0, 15) == 0) : clr_force;
        @(posedge clk);
        model_edge();
        edge_cnt++;
        #1;
        check_val("rx_valid", 32'(rx_valid), 32'(m_valid));
        check_val("frame_err", 32'(frame_err), 32'(exp_ferr));
        check_val("overrun", 32'(overrun), 32'(m_ovr));
        if (m_valid) check_val("rx_data", 32'(rx_data), 32'(m_data));
        if (rx_valid) last_rx = rx_data;
        if (frame_err) ferr_count++;
    endtask

    task automatic push_n(input bit v, input int n);
        for (int i = 0; i < n; i++) sin_fifo.push_back(v);
    endtask

    task automatic send_frame(input logic [DW-1:0] data, input bit stop, input int hold,
                              input int gap, output int ev_edge);
        int s;
        s = edge_cnt + sin_fifo.size();
        push_n(1'b1, CPB);
        for (int i = DW - 1; i >= 0; i--) push_n(data[i], CPB);
        push_n(stop, CPB);
        push_n(1'b1, hold);
        push_n(1'b0, gap);
        ev_edge = s + LAT;
        events.push_back('{ev_edge, (stop == 1'b0), data});
    endtask

    task automatic drain();
        while (sin_fifo.size() > 0) step();
        repeat (4) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int ev1;
        int ev2;
        int steps;
        bit valid_cont;
        logic [DW-1:0] d;
        int kind;

        n_cmp = 0; n_err = 0; edge_cnt = 0; ferr_count = 0; last_rx = '0;
        ready_mode = 1; ready_edge = -1; clr_rand = 0; clr_force = 0;
        m_valid = 0; m_data = '0; m_ovr = 0; exp_ferr = 0;
        sin = 0; rx_ready = 0; clr_overrun = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_rx_valid", 32'(rx_valid), 0);
        check_val("rst_rx_data", 32'(rx_data), 0);
        check_val("rst_frame_err", 32'(frame_err), 0);
        check_val("rst_overrun", 32'(overrun), 0);
        check_val("rst_busy", 32'(busy), 0);
        reset = 1'b1;
        repeat (3) step();

        // Basic frame 0xA5 with latency measurement.
        ready_mode = 1;
        send_frame(8'hA5, 1'b0, 0, 4, ev1);
        steps = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            steps++;
            if (rx_valid) break;
        end
        check_val("a5_latency", 32'(steps), 32'(LAT + 1));
        check_val("a5_data", 32'(rx_data), 32'h A5);
        drain();
        check_val("a5_valid_gone", 32'(rx_valid), 0);

        // Glitch shorter than half a bit.
        push_n(1'b1, 1);
        push_n(1'b0, 6);
        step(); step();
        check_val("glitch_busy_start", 32'(busy), 1);
        drain();
        check_val("glitch_busy_idle", 32'(busy), 0);

        // Bad stop bit followed by a line held high.
        ferr_count = 0;
        send_frame(8'h3C, 1'b1, 20, 3, ev1);
        repeat (LAT + 10) step();
        check_val("break_busy_held", 32'(busy), 1);
        drain();
        check_val("break_ferr_count", 32'(ferr_count), 1);
        check_val("break_busy_idle", 32'(busy), 0);
        check_val("break_no_valid", 32'(rx_valid), 0);

        // Overrun: consumer stalled for two frames.
        ready_mode = 0;
        send_frame(8'h11, 1'b0, 0, 2, ev1);
        send_frame(8'h22, 1'b0, 0, 2, ev2);
        drain();
        check_val("ovr_data_held", 32'(rx_data), 32'h11);
        check_val("ovr_flag", 32'(overrun), 1);
        clr_force = 1; step(); clr_force = 0;
        check_val("ovr_cleared", 32'(overrun), 0);
        ready_mode = 1; step();
        check_val("ovr_consumed", 32'(rx_valid), 0);

        // Accept and load on the same edge.
        ready_mode = 0;
        send_frame(8'h11, 1'b0, 0, 2, ev1);
        send_frame(8'h22, 1'b0, 0, 2, ev2);
        ready_edge = ev2;
        ready_mode = 3;
        valid_cont = 1'b1;
        while (edge_cnt <= ev1) step();
        while (edge_cnt <= ev2) begin
            step();
            valid_cont &= rx_valid;
        end
        check_val("b2b_valid_cont", 32'(valid_cont), 1);
        check_val("b2b_data", 32'(rx_data), 32'h22);
        check_val("b2b_overrun", 32'(overrun), 0);
        ready_mode = 1;
        drain();

        // Reset during a data bit while a word is pending.
        ready_mode = 0;
        send_frame(8'h5A, 1'b0, 0, 2, ev1);
        drain();
        send_frame(8'hFF, 1'b0, 0, 2, ev1);
        repeat (1 + HALF + 4 * CPB + 2) step();
        reset = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(rx_valid), 0);
        check_val("mid_rst_data", 32'(rx_data), 0);
        check_val("mid_rst_busy", 32'(busy), 0);
        check_val("mid_rst_ferr", 32'(frame_err), 0);
        check_val("mid_rst_ovr", 32'(overrun), 0);
        m_valid = 0; m_data = '0; m_ovr = 0;
        events.delete();
        sin_fifo.delete();
        sin = 0;
        @(posedge clk);
        #1;
        edge_cnt++;
        reset = 1'b1;
        ready_mode = 1;
        last_rx = '0;
        send_frame(8'h81, 1'b0, 0, 2, ev1);
        drain();
        check_val("post_rst_data", 32'(last_rx), 32'h81);

        // Random traffic with random consumer and occasional clears.
        ready_mode = 2;
        clr_rand = 1;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 7);
            d = DW'($urandom);
            if (kind == 0) begin
                push_n(1'b1, $urandom_range(1, HALF - 1 > 0 ? HALF - 1 : 1));
                push_n(1'b0, 6);
            end else if (kind == 1) begin
                send_frame(d, 1'b1, $urandom_range(0, 8), $urandom_range(2, 4), ev1);
            end else begin
                send_frame(d, 1'b0, 0, $urandom_range(0, 3), ev1);
            end
            while (sin_fifo.size() > 0) step();
        end
        clr_rand = 0;
        ready_mode = 1;
        drain();
        check_val("events_left", 32'(events.size()), 0);
        check_val("final_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
